alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// - Initiator side of the 8-bit ALU datapath: accepts one command per handshake, drives ALU A/B/S, captures F and flags.
// - Holds a small operand register file and a sticky flag register; returns result + flags to the requester.
// - Sits between the instruction/control source and the combinational ALU (ALU instantiated alongside, not inside).
// PARAMETERS
// - NREGS  4  operand register count (power of 2, >=2); index width RW = log2(NREGS)
// - DW     8  data width; must match ALU operand width
// PORTS
// - CLK        in   1    single clock, all state on posedge
// - RST        in   1    asynchronous, active-high reset
// - CMD_VALID  in   1    command valid
// - CMD_READY  out  1    command accepted when VALID&READY at posedge
// - CMD_OP     in   4    ALU S code
// - CMD_SRCA   in   RW   register index for A
// - CMD_SRCB   in   RW   register index for B (ignored when CMD_IMM_EN=1)
// - CMD_DST    in   RW   writeback register index
// - CMD_WB_EN  in   1    1 = write F to CMD_DST
// - CMD_IMM_EN in   1    1 = B operand taken from CMD_IMM
// - CMD_IMM    in   DW   immediate operand
// - ALU_A/ALU_B out DW   registered operands to ALU
// - ALU_S      out  4    registered opcode to ALU
// - ALU_F      in   DW   ALU result (combinational from ALU_A/B/S)
// - ALU_EQ,ALU_GT,ALU_LT,ALU_ZERO,ALU_CARRY,ALU_OVF  in 1 each  ALU flags
// - RES_VALID  out  1    result valid; held until RES_READY
// - RES_READY  in   1    result consumed when VALID&READY at posedge
// - RES_DATA   out  DW   captured F
// - RES_FLAGS  out  6    {EQ,GT,LT,ZERO,CARRY,OVF} of this op
// - RES_ERR    out  1    1 = illegal opcode, no side effects
// - RD_ADDR    in   RW   debug read index;  RD_DATA out DW  combinational regfile read
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; CMD_READY=1 after release; RES_VALID=0; RES_DATA=0; RES_FLAGS=0;
//   RES_ERR=0; ALU_A=ALU_B=0; ALU_S=4'b0000; all registers and sticky flags=0. In-flight command discarded.
// - FSM IDLE -> ISSUE -> RESP -> IDLE. CMD_READY=1 only in IDLE (combinational from state).
// - IDLE: on VALID&READY latch command; ALU_A<=R[SRCA]; ALU_B<=IMM_EN?IMM:R[SRCB]; ALU_S<=OP.
//   If OP illegal (0010,0100,0101,0110,0111): skip ISSUE, go RESP with RES_ERR=1, RES_DATA=0, RES_FLAGS=0;
//   ALU_A/B/S not updated; no writeback.
// - ISSUE (1 cycle, ALU settles): at end of cycle RES_DATA<=ALU_F; RES_FLAGS<=ALU flags; if WB_EN R[DST]<=ALU_F;
//   sticky flags <= RES_FLAGS value; RES_ERR<=0; go RESP.
// - CARRY/OVF masked to 0 unless OP is 0000 (add) or 0001 (sub); other flags passed as produced.
// - RESP: RES_VALID=1, outputs stable; on RES_READY go IDLE. No new command accepted in the same cycle.
// - Latency: accept at edge T0, RES_VALID high from T1+ (after ISSUE); illegal op: RES_VALID from T0+.
//   Max throughput 1 command / 3 cycles with RES_READY tied high.
// - Hazards: SRCA/SRCB == DST of previous op read the written value (writeback completes before next IDLE accept).
// - DST == SRCA/SRCB in same op: operands read at accept, write at ISSUE end; no conflict.
// - ALU_A/B/S hold last issued values in IDLE/RESP (no toggling while idle).
// - RD_DATA reflects writes from the edge after ISSUE; index out of range impossible (NREGS power of 2).
// STRUCTURE
// - Shared header alu_defs.vh: opcode localparams (OP_ADD..OP_SHL), legal-op mask function,
//   flag bit indices (FLG_EQ..FLG_OVF), FSM state encodings (2-bit).
// - Sub-module alu_regfile: NREGS x DW, 2 comb read ports + debug read port, 1 sync write port, async reset to 0.
// - Top: FSM, command latch, operand muxing, result/flag capture, masking.
// TESTING
// - Reset: RST pulse -> RES_VALID=0, CMD_READY=1, ALU_S=0000, RD_DATA=0 for all RD_ADDR.
// - Load/add: R1<=0x7F (imm via OP 0000 SRCA=R0, IMM 0x7F), then R1+imm 0x01 -> R2: RES_DATA=0x80, OVF=1, CARRY=0, ZERO=0.
// - Sub equal: R3=0x05 minus imm 0x05 -> RES_DATA=0x00, ZERO=1, EQ=1, CARRY=1, OVF=0; logic op AND -> CARRY=OVF=0.
// - Illegal OP 4'b0110 -> RES_VALID one cycle after accept, RES_ERR=1, regfile and ALU_S unchanged.
// - Back-pressure: hold RES_READY=0 for 5 cycles -> RES_VALID/RES_DATA stable, CMD_READY=0 throughout.
// - RST asserted during ISSUE with WB_EN=1 -> RES_VALID never asserts, destination register reads 0x00.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: FSM states, opcode classes,
// result-flag bit positions and opcode helper functions.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0011;

  // Flag vector layout is {EQ,GT,LT,ZERO,CARRY,OVF}
  localparam int FLG_W     = 6;
  localparam int FLG_OVF   = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_LT    = 3;
  localparam int FLG_GT    = 4;
  localparam int FLG_EQ    = 5;

  // Codes 0010 and 0100..0111 are holes in the ALU opcode map
  function automatic logic op_legal(input logic [3:0] op);
    return op[3] || (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic op_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU, result and debug-read signals of the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 8
);
  localparam int RW = $clog2(NREGS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [RW-1:0]     cmd_srca;
  logic [RW-1:0]     cmd_srcb;
  logic [RW-1:0]     cmd_dst;
  logic              cmd_wb_en;
  logic              cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_s;
  logic [DATA_W-1:0] alu_f;
  logic              alu_eq, alu_gt, alu_lt, alu_zero, alu_carry, alu_ovf;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [5:0]        res_flags;
  logic              res_err;
  logic [5:0]        sticky_flags;

  logic [RW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_wb_en, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_s,
    input  alu_f, alu_eq, alu_gt, alu_lt, alu_zero, alu_carry, alu_ovf,
    output res_valid, res_data, res_flags, res_err, sticky_flags,
    input  res_ready,
    input  rd_addr,
    output rd_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_wb_en, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s,
    output alu_f, alu_eq, alu_gt, alu_lt, alu_zero, alu_carry, alu_ovf,
    input  res_valid, res_data, res_flags, res_err, sticky_flags,
    output res_ready,
    output rd_addr,
    input  rd_data
  );
endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// Operand register file: two combinational operand reads, one debug read,
// one synchronous write port, all entries cleared by reset.
module alu_op_sequencer_regfile #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [DATA_W-1:0]        ra_data,
  output logic [DATA_W-1:0]        rb_data,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [DATA_W-1:0]        wd
);
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rd_data = regs[rd_addr];
endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for an external combinational ALU: accepts a command, registers
// operands onto the ALU, captures result/flags and returns them to the requester.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  alu_op_sequencer_if.master bus
);
  localparam int RW = $clog2(NREGS);

  state_t            state, state_nxt;
  logic              accept, legal;
  logic              wb_en_p1;
  logic [RW-1:0]     dst_p1;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic [FLG_W-1:0]  flags_p1;

  // Carry and overflow only mean something for add/sub
  function automatic logic [FLG_W-1:0] mask_flags(input logic [3:0] op,
    input logic eq, gt, lt, zero, carry, ovf);
    logic [FLG_W-1:0] f;
    f            = '0;
    f[FLG_EQ]    = eq;
    f[FLG_GT]    = gt;
    f[FLG_LT]    = lt;
    f[FLG_ZERO]  = zero;
    f[FLG_CARRY] = carry & op_arith(op);
    f[FLG_OVF]   = ovf & op_arith(op);
    return f;
  endfunction

  alu_op_sequencer_regfile #(.NREGS(NREGS), .DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (bus.cmd_srca),
    .rb_addr (bus.cmd_srcb),
    .rd_addr (bus.rd_addr),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_data (bus.rd_data),
    .we      ((state == ST_ISSUE) && wb_en_p1),
    .wa      (dst_p1),
    .wd      (bus.alu_f)
  );

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.res_valid = (state == ST_RESP);
  assign accept        = bus.cmd_valid && (state == ST_IDLE);
  assign legal         = op_legal(bus.cmd_op);
  assign flags_p1      = mask_flags(bus.alu_s, bus.alu_eq, bus.alu_gt, bus.alu_lt,
                                    bus.alu_zero, bus.alu_carry, bus.alu_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.cmd_valid) state_nxt = legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (bus.res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_p1         <= 1'b0;
      dst_p1           <= '0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_s        <= 4'b0000;
      bus.res_data     <= '0;
      bus.res_flags    <= '0;
      bus.res_err      <= 1'b0;
      bus.sticky_flags <= '0;
    end else begin
      // p0 -> p1: command accept, operands onto the ALU
      if (accept) begin
        if (legal) begin
          bus.alu_a <= ra_data;
          bus.alu_b <= bus.cmd_imm_en ? bus.cmd_imm : rb_data;
          bus.alu_s <= bus.cmd_op;
          wb_en_p1  <= bus.cmd_wb_en;
          dst_p1    <= bus.cmd_dst;
        end else begin
          wb_en_p1      <= 1'b0;
          bus.res_err   <= 1'b1;
          bus.res_data  <= '0;
          bus.res_flags <= '0;
        end
      end
      // p1 -> p2: ALU has settled, capture result and flags
      if (state == ST_ISSUE) begin
        bus.res_data     <= bus.alu_f;
        bus.res_flags    <= flags_p1;
        bus.sticky_flags <= flags_p1;
        bus.res_err      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU alongside the DUT, a queue-based
// expected-result model, and directed command vectors with literal expectations.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int NREGS  = 4;
  localparam int DATA_W = 8;
  localparam logic [3:0] T_ADD = 4'b0000, T_SUB = 4'b0001, T_AND = 4'b1000,
                         T_OR  = 4'b1001, T_XOR = 4'b1010, T_ILL = 4'b0110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.NREGS(NREGS), .DATA_W(DATA_W)) bus();
  alu_op_sequencer #(.NREGS(NREGS), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Raw ALU: {EQ,GT,LT,ZERO,CARRY,OVF,F}; carry/ovf come from the adder for every op
  function automatic logic [13:0] alu_ref(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum, dif;
    logic [7:0] f;
    logic c, v;
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    c = sum[8];
    v = (a[7] == b[7]) && (sum[7] != a[7]);
    case (s)
      4'b0000: f = sum[7:0];
      4'b0001: begin f = dif[7:0]; c = ~dif[8]; v = (a[7] != b[7]) && (dif[7] != a[7]); end
      4'b0011: f = dif[7:0];
      4'b1000: f = a & b;
      4'b1001: f = a | b;
      4'b1010: f = a ^ b;
      4'b1011: f = ~a;
      4'b1100: f = a;
      4'b1101: f = b;
      4'b1110: f = a >> 1;
      4'b1111: f = a << 1;
      default: f = 8'h00;
    endcase
    return {a == b, a > b, a < b, f == 8'h00, c, v, f};
  endfunction

  logic [13:0] alu_out;
  assign alu_out       = alu_ref(bus.alu_s, bus.alu_a, bus.alu_b);
  assign bus.alu_f     = alu_out[7:0];
  assign bus.alu_ovf   = alu_out[8];
  assign bus.alu_carry = alu_out[9];
  assign bus.alu_zero  = alu_out[10];
  assign bus.alu_lt    = alu_out[11];
  assign bus.alu_gt    = alu_out[12];
  assign bus.alu_eq    = alu_out[13];

  typedef struct {
    logic [7:0] data;
    logic [5:0] flags;
    logic       err;
    logic [5:0] sticky;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mreg [NREGS];
  logic [5:0] msticky;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Model: what the response to a command must be, given the register contents
  task automatic model_accept(input logic [3:0] op, input int srca, input int srcb, input int dst,
                              input logic wb, input logic imm_en, input logic [7:0] imm);
    exp_t e;
    logic [7:0] a, b;
    logic [13:0] r;
    a = mreg[srca];
    b = imm_en ? imm : mreg[srcb];
    if ((op inside {4'b0000, 4'b0001, 4'b0011}) || op >= 4'b1000) begin
      r = alu_ref(op, a, b);
      e.data  = r[7:0];
      e.flags = r[13:8];
      if (!(op == T_ADD || op == T_SUB)) e.flags[1:0] = 2'b00;
      e.err   = 1'b0;
      msticky = e.flags;
      if (wb) mreg[dst] = r[7:0];
    end else begin
      e.data  = 8'h00;
      e.flags = 6'h00;
      e.err   = 1'b1;
    end
    e.sticky = msticky;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 32'd1, 32'd0);
      end else begin
        chk("res_data", bus.res_data, exp_q[0].data);
        chk("res_flags", bus.res_flags, exp_q[0].flags);
        chk("res_err", bus.res_err, exp_q[0].err);
        chk("sticky", bus.sticky_flags, exp_q[0].sticky);
        chk("cmd_ready_resp", bus.cmd_ready, 32'd0);
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] op, input int srca, input int srcb, input int dst,
                      input logic wb, input logic imm_en, input logic [7:0] imm,
                      output int lat, output logic [7:0] d, output logic [5:0] fl);
    int n;
    n = 0; lat = 0; d = 8'h00; fl = 6'h00;
    @(posedge clk); #1;
    while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_ready) begin chk("cmd_ready_timeout", 32'd0, 32'd1); return; end
    bus.cmd_op = op;
    bus.cmd_srca = srca[1:0];
    bus.cmd_srcb = srcb[1:0];
    bus.cmd_dst = dst[1:0];
    bus.cmd_wb_en = wb;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    model_accept(op, srca, srcb, dst, wb, imm_en, imm);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin lat = k; break; end
    end
    if (lat == 0) chk("res_valid_timeout", 32'd0, 32'd1);
    d  = bus.res_data;
    fl = bus.res_flags;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NREGS; i++) begin
      bus.rd_addr = i[1:0];
      #1;
      chk(name, bus.rd_data, mreg[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] d;
    logic [5:0] fl;
    int n;

    bus.cmd_valid = 1'b0; bus.cmd_op = 4'h0; bus.cmd_srca = '0; bus.cmd_srcb = '0;
    bus.cmd_dst = '0; bus.cmd_wb_en = 1'b0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = 8'h00;
    bus.res_ready = 1'b1; bus.rd_addr = '0;
    for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
    msticky = 6'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 32'd0);
    chk("rst_cmd_ready", bus.cmd_ready, 32'd1);
    chk("rst_alu_s", bus.alu_s, 32'h0);
    chk("rst_res_data", bus.res_data, 32'h0);
    chk("rst_sticky", bus.sticky_flags, 32'h0);
    rst = 1'b0;
    check_regs("rst_rd_data");

    // R1 <= 0 + 0x7F
    send(T_ADD, 0, 0, 1, 1'b1, 1'b1, 8'h7F, lat, d, fl);
    chk("load_lat", lat, 32'd2);
    chk("load_data", d, 32'h7F);
    // R2 <= 0x7F + 1: signed overflow, no carry
    send(T_ADD, 1, 0, 2, 1'b1, 1'b1, 8'h01, lat, d, fl);
    chk("add_data", d, 32'h80);
    chk("add_flags", fl, 32'b010001);
    // R3 <= 5, then 5 - 5
    send(T_ADD, 0, 0, 3, 1'b1, 1'b1, 8'h05, lat, d, fl);
    send(T_SUB, 3, 0, 0, 1'b0, 1'b1, 8'h05, lat, d, fl);
    chk("sub_data", d, 32'h00);
    chk("sub_flags", fl, 32'b100110);
    // AND: raw adder carry/ovf are both 1 here and must be masked
    send(T_AND, 2, 0, 0, 1'b0, 1'b1, 8'h80, lat, d, fl);
    chk("and_data", d, 32'h80);
    chk("and_flags", fl, 32'b100000);

    // Illegal opcode with writeback requested
    send(T_ILL, 1, 1, 1, 1'b1, 1'b0, 8'hAA, lat, d, fl);
    chk("ill_lat", lat, 32'd1);
    chk("ill_err", bus.res_err, 32'd1);
    chk("ill_data", d, 32'h00);
    chk("ill_flags", fl, 32'h00);
    chk("ill_alu_s", bus.alu_s, {28'h0, T_AND});
    bus.rd_addr = 2'd1; #1;
    chk("ill_r1_kept", bus.rd_data, 32'h7F);

    // Read-after-write across commands, DST == SRCA within one command
    send(T_ADD, 2, 3, 2, 1'b1, 1'b0, 8'h00, lat, d, fl);
    chk("raw_add_data", d, 32'h85);
    send(T_OR, 2, 0, 1, 1'b1, 1'b1, 8'h00, lat, d, fl);
    chk("raw_or_data", d, 32'h85);
    check_regs("regs_after_hazard");

    // Back-pressure
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    send(T_XOR, 1, 0, 0, 1'b0, 1'b1, 8'h0F, lat, d, fl);
    chk("bp_data", d, 32'h8A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.res_valid, 32'd1);
      chk("bp_hold", bus.res_data, 32'h8A);
      chk("bp_cmd_ready", bus.cmd_ready, 32'd0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;

    // Reset while the command is in ISSUE with writeback enabled
    n = 0;
    @(posedge clk); #1;
    while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre_rst_ready", bus.cmd_ready, 32'd1);
    bus.cmd_op = T_ADD; bus.cmd_srca = 2'd0; bus.cmd_dst = 2'd3;
    bus.cmd_wb_en = 1'b1; bus.cmd_imm_en = 1'b1; bus.cmd_imm = 8'h55;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
    msticky = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_issue_no_valid", bus.res_valid, 32'd0);
    end
    bus.rd_addr = 2'd3; #1;
    chk("rst_issue_r3", bus.rd_data, 32'h00);
    check_regs("regs_after_rst");

    // Normal operation resumes
    send(T_ADD, 0, 0, 0, 1'b1, 1'b1, 8'h01, lat, d, fl);
    chk("resume_lat", lat, 32'd2);
    chk("resume_data", d, 32'h01);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
